// File: rtl/collision_scheduler.sv
// Per-frame collision scheduler: snapshots player/bullet positions on frame_tick,
// scans one bullet slot per cycle with a single squared-distance comparator.
module collision_scheduler #(
   parameter int NUM_BULLETS   = 8,
   parameter int RADIUS_SQ     = 225,
   parameter int IFRAME_FRAMES = 60
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      frame_tick,
   input  logic [9:0]                player_x,
   input  logic [9:0]                player_y,
   input  logic [10*NUM_BULLETS-1:0] bullet_x_flat,
   input  logic [10*NUM_BULLETS-1:0] bullet_y_flat,
   input  logic [NUM_BULLETS-1:0]    bullet_active,
   output logic                      busy,
   output logic                      scan_done,
   output logic                      hit,
   output logic [3:0]                hit_index,
   output logic                      invuln
);

   typedef enum logic [1:0] {IDLE, LATCH, SCAN, DONE} state_t;

   localparam logic [3:0]  LAST_INDEX  = 4'(NUM_BULLETS - 1);
   localparam logic [7:0]  IFRAME_LOAD = 8'(IFRAME_FRAMES);
   localparam logic [20:0] RADIUS_LIM  = 21'(RADIUS_SQ);

   state_t state_reg, state_next;

   logic [3:0] index_reg, index_next;
   logic       found_reg, found_next;
   logic [3:0] found_index_reg, found_index_next;
   logic [7:0] counter_reg, counter_next;

   logic       busy_reg, busy_next;
   logic       scan_done_reg, scan_done_next;
   logic       hit_reg, hit_next;
   logic [3:0] hit_index_reg, hit_index_next;
   logic       invuln_reg, invuln_next;
   logic       load_iframes;

   logic [9:0]             snap_px_reg, snap_py_reg;
   logic [9:0]             snap_x_reg [NUM_BULLETS];
   logic [9:0]             snap_y_reg [NUM_BULLETS];
   logic [NUM_BULLETS-1:0] snap_active_reg;

   logic [9:0]  cur_x, cur_y;
   logic        cur_active;
   logic [9:0]  dx, dy;
   logic [19:0] dx_sq, dy_sq;
   logic [20:0] dist_sq;
   logic        collide;

   // Snapshot is taken only in LATCH so later input changes cannot disturb the scan
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_px_reg     <= '0;
         snap_py_reg     <= '0;
         snap_active_reg <= '0;
         for (int i = 0; i < NUM_BULLETS; i++) begin
            snap_x_reg[i] <= '0;
            snap_y_reg[i] <= '0;
         end
      end else if (state_reg == LATCH) begin
         snap_px_reg     <= player_x;
         snap_py_reg     <= player_y;
         snap_active_reg <= bullet_active;
         for (int i = 0; i < NUM_BULLETS; i++) begin
            snap_x_reg[i] <= bullet_x_flat[10*i +: 10];
            snap_y_reg[i] <= bullet_y_flat[10*i +: 10];
         end
      end
   end

   always_comb begin
      cur_x      = '0;
      cur_y      = '0;
      cur_active = 1'b0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         if (index_reg == i[3:0]) begin
            cur_x      = snap_x_reg[i];
            cur_y      = snap_y_reg[i];
            cur_active = snap_active_reg[i];
         end
      end
   end

   // Magnitudes are formed by ordered subtraction so they never wrap
   assign dx      = (snap_px_reg >= cur_x) ? (snap_px_reg - cur_x) : (cur_x - snap_px_reg);
   assign dy      = (snap_py_reg >= cur_y) ? (snap_py_reg - cur_y) : (cur_y - snap_py_reg);
   assign dx_sq   = {10'd0, dx} * {10'd0, dx};
   assign dy_sq   = {10'd0, dy} * {10'd0, dy};
   assign dist_sq = {1'b0, dx_sq} + {1'b0, dy_sq};
   assign collide = cur_active && (dist_sq <= RADIUS_LIM);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (frame_tick) state_next = LATCH;
         LATCH:   state_next = SCAN;
         SCAN:    if (index_reg == LAST_INDEX) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      index_next       = index_reg;
      found_next       = found_reg;
      found_index_next = found_index_reg;
      scan_done_next   = 1'b0;
      hit_next         = 1'b0;
      hit_index_next   = hit_index_reg;
      load_iframes     = 1'b0;
      case (state_reg)
         LATCH: begin
            found_next = 1'b0;
            index_next = '0;
         end
         SCAN: begin
            if (collide && !found_reg) begin
               found_next       = 1'b1;
               found_index_next = index_reg;
            end
            if (index_reg != LAST_INDEX) index_next = index_reg + 4'd1;
         end
         DONE: begin
            scan_done_next = 1'b1;
            if (found_reg && (counter_reg == 8'd0)) begin
               hit_next       = 1'b1;
               hit_index_next = found_index_reg;
               load_iframes   = 1'b1;
            end
         end
         default: ;
      endcase

      // A load in DONE takes priority over a coincident tick decrement
      counter_next = counter_reg;
      if (load_iframes) begin
         counter_next = IFRAME_LOAD;
      end else if (frame_tick && (counter_reg != 8'd0)) begin
         counter_next = counter_reg - 8'd1;
      end

      busy_next   = (state_next != IDLE);
      invuln_next = (counter_next != 8'd0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         index_reg       <= '0;
         found_reg       <= 1'b0;
         found_index_reg <= '0;
         counter_reg     <= '0;
         busy_reg        <= 1'b0;
         scan_done_reg   <= 1'b0;
         hit_reg         <= 1'b0;
         hit_index_reg   <= '0;
         invuln_reg      <= 1'b0;
      end else begin
         index_reg       <= index_next;
         found_reg       <= found_next;
         found_index_reg <= found_index_next;
         counter_reg     <= counter_next;
         busy_reg        <= busy_next;
         scan_done_reg   <= scan_done_next;
         hit_reg         <= hit_next;
         hit_index_reg   <= hit_index_next;
         invuln_reg      <= invuln_next;
      end
   end

   assign busy      = busy_reg;
   assign scan_done = scan_done_reg;
   assign hit       = hit_reg;
   assign hit_index = hit_index_reg;
   assign invuln    = invuln_reg;

endmodule

// File: tb/tb_collision_scheduler.sv
// Bench for collision_scheduler: table vectors, hand-written corner sequences and
// randomized frames checked against a distance-rule reference model.
module tb_collision_scheduler;

   localparam int NB = 8;
   localparam int RSQ = 225;
   localparam int IFR = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          frame_tick = 1'b0;
   logic [9:0]    player_x = '0;
   logic [9:0]    player_y = '0;
   logic [10*NB-1:0] bullet_x_flat = '0;
   logic [10*NB-1:0] bullet_y_flat = '0;
   logic [NB-1:0] bullet_active = '0;
   logic          busy, scan_done, hit, invuln;
   logic [3:0]    hit_index;

   collision_scheduler #(
      .NUM_BULLETS(NB), .RADIUS_SQ(RSQ), .IFRAME_FRAMES(IFR)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick),
      .player_x(player_x), .player_y(player_y),
      .bullet_x_flat(bullet_x_flat), .bullet_y_flat(bullet_y_flat),
      .bullet_active(bullet_active),
      .busy(busy), .scan_done(scan_done), .hit(hit),
      .hit_index(hit_index), .invuln(invuln)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int px_m, py_m;
   int bx_m [NB];
   int by_m [NB];
   bit act_m [NB];
   int cnt_m = 0;
   int last_m = 0;

   typedef struct {
      int         px, py;
      logic [79:0] bx, by;
      logic [7:0] act;
      bit         eh;
      int         ei;
   } vec_t;

   vec_t tbl [10];
   int   ntbl = 0;

   task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic add_vec(input int px, input int py,
                          input int sa, input int xa, input int ya,
                          input int sb, input int xb, input int yb,
                          input logic [7:0] act, input bit eh, input int ei);
      logic [79:0] vx, vy;
      vx = '0;
      vy = '0;
      vx[10*sa +: 10] = 10'(xa);
      vy[10*sa +: 10] = 10'(ya);
      vx[10*sb +: 10] = 10'(xb);
      vy[10*sb +: 10] = 10'(yb);
      tbl[ntbl].px  = px;
      tbl[ntbl].py  = py;
      tbl[ntbl].bx  = vx;
      tbl[ntbl].by  = vy;
      tbl[ntbl].act = act;
      tbl[ntbl].eh  = eh;
      tbl[ntbl].ei  = ei;
      ntbl++;
   endtask

   // Lowest active slot within the radius, by plain integer distance
   task automatic model_scan(output bit f, output int idx);
      f = 0;
      idx = 0;
      for (int i = 0; i < NB; i++) begin
         int ddx, ddy;
         ddx = px_m - bx_m[i];
         ddy = py_m - by_m[i];
         if (!f && act_m[i] && (ddx * ddx + ddy * ddy <= RSQ)) begin
            f = 1;
            idx = i;
         end
      end
   endtask

   task automatic drive_inputs();
      player_x = 10'(px_m);
      player_y = 10'(py_m);
      for (int i = 0; i < NB; i++) begin
         bullet_x_flat[10*i +: 10] = 10'(bx_m[i]);
         bullet_y_flat[10*i +: 10] = 10'(by_m[i]);
         bullet_active[i] = act_m[i];
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      cnt_m = 0;
      last_m = 0;
   endtask

   task automatic run_frame(input bit extra, input bit scramble,
                            output bit obs_hit, output int obs_idx);
      bit f, early, exp_hit;
      int idx;
      model_scan(f, idx);
      drive_inputs();
      early = 0;
      exp_hit = 0;
      obs_hit = 0;
      obs_idx = 0;
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      if (cnt_m > 0) cnt_m--;
      #1 frame_tick = 1'b0;
      chk("busy_after_tick", 32'(busy), 32'd1);
      chk("invuln_after_tick", 32'(invuln), 32'(cnt_m != 0));
      for (int k = 1; k <= NB + 2; k++) begin
         @(posedge clk);
         if (extra && k == 4 && cnt_m > 0) cnt_m--;
         #1;
         if (k == 1 && scramble) begin
            player_x = 10'($urandom_range(1023));
            player_y = 10'($urandom_range(1023));
            for (int i = 0; i < NB; i++) begin
               bullet_x_flat[10*i +: 10] = 10'($urandom_range(1023));
               bullet_y_flat[10*i +: 10] = 10'($urandom_range(1023));
            end
            bullet_active = 8'($urandom_range(255));
         end
         if (extra && k == 3) frame_tick = 1'b1;
         if (extra && k == 4) frame_tick = 1'b0;
         if (k < NB + 2) begin
            if (scan_done || hit) early = 1;
         end else begin
            if (f && cnt_m == 0) begin
               exp_hit = 1;
               cnt_m = IFR;
               last_m = idx;
            end
            chk("scan_done", 32'(scan_done), 32'd1);
            chk("hit", 32'(hit), 32'(exp_hit));
            chk("hit_index", 32'(hit_index), 32'(last_m));
            chk("invuln_done", 32'(invuln), 32'(cnt_m != 0));
            obs_hit = hit;
            obs_idx = int'(hit_index);
         end
      end
      chk("no_early_done", 32'(early), 32'd0);
      @(posedge clk);
      #1;
      chk("done_pulse_width", 32'(scan_done | hit), 32'd0);
      chk("busy_released", 32'(busy), 32'd0);
   endtask

   task automatic clear_model_bullets();
      for (int i = 0; i < NB; i++) begin
         bx_m[i] = 0;
         by_m[i] = 0;
         act_m[i] = 0;
      end
   endtask

   initial begin
      bit oh;
      int oi;
      bit stray;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_scan_done", 32'(scan_done), 32'd0);
      chk("rst_hit", 32'(hit), 32'd0);
      chk("rst_hit_index", 32'(hit_index), 32'd0);
      chk("rst_invuln", 32'(invuln), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      add_vec(100, 100, 3, 110, 105, 3, 110, 105, 8'b0000_1000, 1, 3);
      add_vec(200, 200, 0, 209, 212, 0, 209, 212, 8'b0000_0001, 1, 0);
      add_vec(200, 200, 0, 209, 213, 0, 209, 213, 8'b0000_0001, 0, 0);
      add_vec(5, 5, 0, 1000, 5, 0, 1000, 5, 8'b0000_0001, 0, 0);
      add_vec(3, 3, 0, 0, 0, 0, 0, 0, 8'b0000_0001, 1, 0);
      add_vec(100, 100, 2, 100, 100, 6, 104, 98, 8'b0100_0100, 1, 2);
      add_vec(100, 100, 2, 100, 100, 6, 104, 98, 8'b0100_0000, 1, 6);
      add_vec(100, 100, 2, 100, 100, 6, 100, 100, 8'b0000_0000, 0, 0);
      add_vec(500, 500, 7, 515, 500, 7, 515, 500, 8'b1111_1111, 1, 7);
      add_vec(1023, 0, 4, 1023, 15, 5, 1023, 16, 8'b0011_0000, 1, 4);

      for (int k = 0; k < ntbl; k++) begin
         do_reset();
         px_m = tbl[k].px;
         py_m = tbl[k].py;
         for (int i = 0; i < NB; i++) begin
            bx_m[i]  = int'(tbl[k].bx[10*i +: 10]);
            by_m[i]  = int'(tbl[k].by[10*i +: 10]);
            act_m[i] = tbl[k].act[i];
         end
         run_frame(0, 0, oh, oi);
         chk($sformatf("tbl%0d_hit", k), 32'(oh), 32'(tbl[k].eh));
         chk($sformatf("tbl%0d_idx", k), 32'(oi), 32'(tbl[k].ei));
      end

      // Invulnerability window with a persistent collider
      do_reset();
      clear_model_bullets();
      px_m = 300; py_m = 300;
      bx_m[1] = 305; by_m[1] = 300; act_m[1] = 1;
      run_frame(0, 0, oh, oi);
      chk("iframe_f0_hit", 32'(oh), 32'd1);
      run_frame(0, 0, oh, oi);
      chk("iframe_f1_hit", 32'(oh), 32'd0);
      run_frame(0, 0, oh, oi);
      chk("iframe_f2_hit", 32'(oh), 32'd0);
      chk("iframe_invuln_before_f3", 32'(invuln), 32'd1);
      run_frame(0, 0, oh, oi);
      chk("iframe_f3_hit", 32'(oh), 32'd1);

      // Extra ticks during a scan must neither restart nor queue a scan
      do_reset();
      run_frame(1, 0, oh, oi);
      stray = 0;
      repeat (NB + 4) begin
         @(posedge clk);
         #1;
         if (scan_done || busy) stray = 1;
      end
      chk("no_queued_scan", 32'(stray), 32'd0);

      // Reset in the middle of a scan
      do_reset();
      run_frame(0, 0, oh, oi);
      @(negedge clk);
      frame_tick = 1'b1;
      @(posedge clk);
      #1 frame_tick = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("midscan_busy_pre", 32'(busy), 32'd1);
      chk("midscan_invuln_pre", 32'(invuln), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midscan_rst_busy", 32'(busy), 32'd0);
      chk("midscan_rst_invuln", 32'(invuln), 32'd0);
      chk("midscan_rst_hit_index", 32'(hit_index), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      cnt_m = 0;
      last_m = 0;
      run_frame(0, 0, oh, oi);
      chk("post_reset_hit", 32'(oh), 32'd1);

      // Randomized frames, clustered near the player so hits are common
      do_reset();
      for (int n = 0; n < 60; n++) begin
         px_m = int'($urandom_range(1023));
         py_m = int'($urandom_range(1023));
         if ($urandom_range(7) == 0) px_m = 0;
         if ($urandom_range(7) == 0) py_m = 1023;
         for (int i = 0; i < NB; i++) begin
            int ox, oy;
            ox = px_m + int'($urandom_range(40)) - 20;
            oy = py_m + int'($urandom_range(40)) - 20;
            bx_m[i] = (ox < 0) ? 0 : (ox > 1023) ? 1023 : ox;
            by_m[i] = (oy < 0) ? 0 : (oy > 1023) ? 1023 : oy;
            act_m[i] = ($urandom_range(3) == 0);
         end
         run_frame(bit'($urandom_range(1)), bit'($urandom_range(1)), oh, oi);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
